// File: rtl/rv_uart_pkg.sv
// rv_uart_pkg: register map, status bit positions and FSM state types shared by the UART
package rv_uart_pkg;
   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV = 2'd2;
   localparam int ST_TX_FULL = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_RX_OVR = 3;
   localparam int ST_TX_BUSY = 4;
   localparam int ST_FRAME_ERR = 5;
   localparam int ST_IRQ_TX_EN = 8;
   localparam logic [15:0] DIV_MIN = 16'd4;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
endpackage

// File: rtl/rv_uart_fifo.sv
// rv_uart_fifo: synchronous FIFO; extra pointer bit separates full from empty across wrap
module rv_uart_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty = wp == rp;
   assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
   assign do_pop = pop & ~empty;
   // a pop frees the slot being written, so a full FIFO still accepts a simultaneous push
   assign do_push = push & (~full | do_pop);
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (AW+1)'(1);
         if (do_pop) rp <= rp + (AW+1)'(1);
      end
   always_ff @(posedge i_clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/rv_wb_uart.sv
// rv_wb_uart: Wishbone slave UART with TX FIFO, 8N1 transmitter/receiver and programmable baud divisor
module rv_wb_uart
   import rv_uart_pkg::*;
#(
   parameter logic [15:0] DIV_RESET = 16'd434,
   parameter int TX_DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [3:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   output logic [31:0] o_wb_dat,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_stb,
   input  logic        i_wb_cyc,
   output logic        o_wb_ack,
   input  logic        i_rx,
   output logic        o_tx,
   output logic        o_irq
);
   logic acc, wr, rd, data_rd, stat_wr, push, pop, full, empty, tx_busy, tx_end;
   logic s1, s2, s3, r_half, r_end, stop_hit, rx_valid, ovr, ferr, irq_en, unused_bits;
   logic [1:0] reg_sel;
   logic [15:0] div, div_eff, tcnt, tdiv, rcnt, rdiv;
   logic [7:0] dout, tsh, rsh, rx_byte;
   logic [2:0] tbit, rbit;
   logic [31:0] status, rdata;
   tx_state_t ts;
   rx_state_t rs;
   assign acc = i_wb_stb & i_wb_cyc;
   assign wr = acc & i_wb_we;
   assign rd = acc & ~i_wb_we;
   assign reg_sel = i_wb_adr[3:2];
   assign data_rd = rd && reg_sel == REG_DATA;
   assign stat_wr = wr && reg_sel == REG_STATUS;
   assign push = wr && reg_sel == REG_DATA && i_wb_sel[0];
   assign div_eff = div < DIV_MIN ? DIV_MIN : div;
   assign unused_bits = ^{i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};
   rv_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .push(push), .pop(pop),
      .din(i_wb_dat[7:0]), .full(full), .empty(empty), .dout(dout)
   );
   always_comb begin
      status = '0;
      status[ST_TX_FULL] = full;
      status[ST_TX_EMPTY] = empty;
      status[ST_RX_VALID] = rx_valid;
      status[ST_RX_OVR] = ovr;
      status[ST_TX_BUSY] = tx_busy;
      status[ST_FRAME_ERR] = ferr;
      status[ST_IRQ_TX_EN] = irq_en;
   end
   assign rdata = reg_sel == REG_DATA ? {24'b0, rx_valid ? rx_byte : 8'h00}
                : reg_sel == REG_STATUS ? status
                : reg_sel == REG_DIV ? {16'b0, div} : 32'b0;
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         div <= DIV_RESET;
         irq_en <= 1'b0;
         o_wb_ack <= 1'b0;
         o_wb_dat <= '0;
      end else begin
         o_wb_ack <= acc;
         o_wb_dat <= rd ? rdata : '0;
         if (wr && reg_sel == REG_DIV && i_wb_sel[0]) div[7:0] <= i_wb_dat[7:0];
         if (wr && reg_sel == REG_DIV && i_wb_sel[1]) div[15:8] <= i_wb_dat[15:8];
         if (stat_wr && i_wb_sel[1]) irq_en <= i_wb_dat[ST_IRQ_TX_EN];
      end
   // transmitter: STOP hands straight to START when another byte is queued
   assign tx_end = tcnt == tdiv - 16'd1;
   assign pop = ~empty && (ts == T_IDLE || (ts == T_STOP && tx_end));
   assign tx_busy = ~empty || ts != T_IDLE;
   assign o_tx = ts == T_START ? 1'b0 : ts == T_DATA ? tsh[0] : 1'b1;
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         ts <= T_IDLE;
         tcnt <= '0;
         tdiv <= DIV_MIN;
         tbit <= '0;
         tsh <= '0;
      end else if (pop) begin
         ts <= T_START;
         tsh <= dout;
         tdiv <= div_eff;
         tcnt <= '0;
      end else if (ts != T_IDLE) begin
         tcnt <= tx_end ? '0 : tcnt + 16'd1;
         if (tx_end) ts <= ts == T_START ? T_DATA : ts == T_STOP ? T_IDLE : tbit == 3'd7 ? T_STOP : T_DATA;
         if (tx_end && ts == T_DATA) begin
            tsh <= tsh >> 1;
            tbit <= tbit + 3'd1;
         end
      end
   // receiver samples mid-bit on the synchronized line s2; s3 is its previous value for edge detect
   assign r_half = rcnt == (rdiv >> 1) - 16'd1;
   assign r_end = rcnt == rdiv - 16'd1;
   assign stop_hit = rs == R_STOP && r_end;
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         {s3, s2, s1} <= 3'b111;
         rs <= R_IDLE;
         rcnt <= '0;
         rdiv <= DIV_MIN;
         rbit <= '0;
         rsh <= '0;
      end else begin
         {s3, s2, s1} <= {s2, s1, i_rx};
         if (rs == R_IDLE) begin
            rcnt <= '0;
            if (s3 && !s2) begin
               rs <= R_START;
               rdiv <= div_eff;
            end
         end else if (rs == R_START) begin
            rcnt <= r_half ? '0 : rcnt + 16'd1;
            if (r_half) rs <= s2 ? R_IDLE : R_DATA;
         end else begin
            rcnt <= r_end ? '0 : rcnt + 16'd1;
            if (r_end && rs == R_DATA) begin
               rsh <= {s2, rsh[7:1]};
               rbit <= rbit + 3'd1;
               if (rbit == 3'd7) rs <= R_STOP;
            end
            if (stop_hit) rs <= R_IDLE;
         end
      end
   // a load coinciding with a DATA read wins and is not an overrun
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         rx_valid <= 1'b0;
         rx_byte <= '0;
         ovr <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if (stat_wr && i_wb_sel[0] && i_wb_dat[ST_RX_OVR]) ovr <= 1'b0;
         if (stat_wr && i_wb_sel[0] && i_wb_dat[ST_FRAME_ERR]) ferr <= 1'b0;
         if (stop_hit && !s2) ferr <= 1'b1;
         if (stop_hit && s2 && rx_valid && !data_rd) ovr <= 1'b1;
         if (stop_hit && s2 && (!rx_valid || data_rd)) begin
            rx_byte <= rsh;
            rx_valid <= 1'b1;
         end else if (data_rd) rx_valid <= 1'b0;
      end
   assign o_irq = rx_valid | (empty & irq_en);
endmodule
